// File: rtl/alu16_if.sv
// Operand/request and result/status bundle between the reg16 file and alu16_seq.
interface alu16_if #(
  parameter int unsigned WIDTH = 16
) ();
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       op;
  logic             start;
  logic             busy;
  logic             done;
  logic             illegal;
  logic [WIDTH-1:0] result;
  logic [3:0]       flags;

  modport master (
    output a, b, op, start,
    input  busy, done, illegal, result, flags
  );

  modport slave (
    input  a, b, op, start,
    output busy, done, illegal, result, flags
  );
endinterface

// File: rtl/alu16_seq.sv
// 16-bit sequential ALU: single-cycle ops via EXEC, iterative shift-add MUL.
// Optional feature macro: ALU_MUL_EN (defined = op 11 runs the iterative
// multiplier; undefined = op 11 is reported as illegal).
module alu16_seq #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned SHAMT_W = 4
) (
  input  logic    clk,
  input  logic    rst_n,
  alu16_if.slave  alu
);
  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_SHL = 4'd6;
  localparam logic [3:0] OP_SHR = 4'd7;
  localparam logic [3:0] OP_ASR = 4'd8;
  localparam logic [3:0] OP_INC = 4'd9;
  localparam logic [3:0] OP_CMP = 4'd10;
  localparam logic [3:0] OP_MUL = 4'd11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1
`ifdef ALU_MUL_EN
    , S_MUL = 2'd2
`endif
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       flags_q, flags_d;
  logic             busy_q, busy_d, done_q, done_d, illegal_q, illegal_d;

`ifdef ALU_MUL_EN
  localparam int unsigned CNT_W = $clog2(WIDTH);
  logic [2*WIDTH-1:0] mcand_q, mcand_d, acc_q, acc_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
`endif

  logic [WIDTH:0]     add_ext, sub_ext, inc_ext, shl_ext, shr_ext, asr_ext;
  logic [SHAMT_W-1:0] sh;
  logic [WIDTH-1:0]   alu_val;
  logic               alu_c, alu_v, alu_ill, wr_res, wr_flg;

  assign sh      = b_q[SHAMT_W-1:0];
  assign add_ext = {1'b0, a_q} + {1'b0, b_q};
  assign sub_ext = {1'b0, a_q} - {1'b0, b_q};
  assign inc_ext = {1'b0, a_q} + (WIDTH+1)'(1);
  assign shl_ext = {1'b0, a_q} << sh;
  assign shr_ext = {a_q, 1'b0} >> sh;
  assign asr_ext = $signed({a_q, 1'b0}) >>> sh;

  // Result value, carry/overflow and write enables for the latched opcode.
  always_comb begin
    alu_val = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_ill = 1'b0;
    wr_res  = 1'b1;
    wr_flg  = 1'b1;
    case (op_q)
      OP_ADD: begin
        alu_val = add_ext[WIDTH-1:0];
        alu_c   = add_ext[WIDTH];
        alu_v   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (add_ext[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SUB, OP_CMP: begin
        alu_val = sub_ext[WIDTH-1:0];
        alu_c   = sub_ext[WIDTH];
        alu_v   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sub_ext[WIDTH-1] != a_q[WIDTH-1]);
        wr_res  = (op_q == OP_SUB);
      end
      OP_AND: alu_val = a_q & b_q;
      OP_OR:  alu_val = a_q | b_q;
      OP_XOR: alu_val = a_q ^ b_q;
      OP_NOT: alu_val = ~a_q;
      OP_SHL: begin
        alu_val = shl_ext[WIDTH-1:0];
        alu_c   = shl_ext[WIDTH];
      end
      OP_SHR: begin
        alu_val = shr_ext[WIDTH:1];
        alu_c   = shr_ext[0];
      end
      OP_ASR: begin
        alu_val = asr_ext[WIDTH:1];
        alu_c   = asr_ext[0];
      end
      OP_INC: begin
        alu_val = inc_ext[WIDTH-1:0];
        alu_c   = inc_ext[WIDTH];
        alu_v   = !a_q[WIDTH-1] && inc_ext[WIDTH-1];
      end
`ifdef ALU_MUL_EN
      OP_MUL: begin
        alu_val = acc_q[WIDTH-1:0];
        alu_c   = |acc_q[2*WIDTH-1:WIDTH];
        alu_v   = |acc_q[2*WIDTH-1:WIDTH];
      end
`endif
      default: begin
        alu_ill = 1'b1;
        wr_res  = 1'b0;
        wr_flg  = 1'b0;
      end
    endcase
  end

  // Next-state, operand latch, multiplier iteration and completion writes.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    result_d  = result_q;
    flags_d   = flags_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    illegal_d = 1'b0;
`ifdef ALU_MUL_EN
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (alu.start) begin
          a_d     = alu.a;
          b_d     = alu.b;
          op_d    = alu.op;
          busy_d  = 1'b1;
          state_d = S_EXEC;
`ifdef ALU_MUL_EN
          if (alu.op == OP_MUL) begin
            state_d  = S_MUL;
            mcand_d  = {{WIDTH{1'b0}}, alu.a};
            mplier_d = alu.b;
            acc_d    = '0;
            cnt_d    = '0;
          end
`endif
        end
      end
      S_EXEC: begin
        state_d   = S_IDLE;
        busy_d    = 1'b0;
        done_d    = 1'b1;
        illegal_d = alu_ill;
        if (wr_res) result_d = alu_val;
        if (wr_flg) flags_d = {(alu_val == '0), alu_val[WIDTH-1], alu_c, alu_v};
      end
`ifdef ALU_MUL_EN
      S_MUL: begin
        acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH-1)) state_d = S_EXEC;
      end
`endif
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset aborts any op in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      result_q  <= '0;
      flags_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
`ifdef ALU_MUL_EN
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      op_q      <= op_d;
      result_q  <= result_d;
      flags_q   <= flags_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
`ifdef ALU_MUL_EN
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign alu.busy    = busy_q;
  assign alu.done    = done_q;
  assign alu.illegal = illegal_q;
  assign alu.result  = result_q;
  assign alu.flags   = flags_q;
endmodule

// File: tb/tb_alu16_seq.sv
// Scoreboard bench for alu16_seq: stimulus queues expected responses, a
// forked monitor checks every done pulse against the queue head.
module tb_alu16_seq;
  localparam int unsigned W = 16;

  typedef struct packed {
    logic [15:0] res;
    logic [3:0]  flg;
    logic        ill;
    logic [3:0]  op;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  alu16_if #(.WIDTH(W)) bus ();

  alu16_seq #(.WIDTH(W), .SHAMT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .alu   (bus)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // Issue one op, queue its expected response, and measure edges to done.
  task automatic run_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] res, input logic [3:0] flg, input logic ill,
                        input int lat, input bit inject);
    int n;
    @(negedge clk);
    bus.op = op; bus.a = a; bus.b = b; bus.start = 1'b1;
    sb.push_back('{res, flg, ill, op});
    @(posedge clk);
    #1 bus.start = 1'b0;
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      if (inject && n == 5) begin
        bus.op = 4'd0; bus.a = 16'h1111; bus.b = 16'h2222; bus.start = 1'b1;
      end
      @(posedge clk);
      #1 bus.start = 1'b0;
      n++;
      if (inject && n == 6) chk("busy_during_ignored_start", 32'(bus.busy), 32'd1);
      if (bus.done) break;
    end
    chk($sformatf("latency_op%0d", op), n, lat);
  endtask

  initial begin
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.op = '0;
    rst_n = 1'b1;

    fork
      forever begin
        exp_t e;
        @(negedge clk);
        if (rst_n && bus.done) begin
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL spurious_done got res=%h flg=%b", bus.result, bus.flags);
          end else begin
            e = sb.pop_front();
            if (bus.result !== e.res || bus.flags !== e.flg || bus.illegal !== e.ill) begin
              errors++;
              $display("FAIL resp_op%0d got res=%h flg=%b ill=%b want res=%h flg=%b ill=%b",
                       e.op, bus.result, bus.flags, bus.illegal, e.res, e.flg, e.ill);
            end
          end
        end
      end
    join_none

    #1 rst_n = 1'b0;
    #1;
    chk("reset_result",  32'(bus.result),  32'h0);
    chk("reset_flags",   32'(bus.flags),   32'h0);
    chk("reset_busy",    32'(bus.busy),    32'h0);
    chk("reset_done",    32'(bus.done),    32'h0);
    chk("reset_illegal", 32'(bus.illegal), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op(4'd0,  16'h7FFF, 16'h0001, 16'h8000, 4'b0101, 1'b0, 1, 1'b0); // ADD overflow
    run_op(4'd1,  16'h0005, 16'h0005, 16'h0000, 4'b1000, 1'b0, 1, 1'b0); // SUB zero
    run_op(4'd10, 16'h0003, 16'h0005, 16'h0000, 4'b0110, 1'b0, 1, 1'b0); // CMP borrow
    run_op(4'd9,  16'hFFFF, 16'h0000, 16'h0000, 4'b1010, 1'b0, 1, 1'b0); // INC wrap
    run_op(4'd6,  16'h8001, 16'h0001, 16'h0002, 4'b0010, 1'b0, 1, 1'b0); // SHL carry
    run_op(4'd7,  16'h8001, 16'h0001, 16'h4000, 4'b0010, 1'b0, 1, 1'b0); // SHR carry
    run_op(4'd8,  16'h8000, 16'h0004, 16'hF800, 4'b0100, 1'b0, 1, 1'b0); // ASR
`ifdef ALU_MUL_EN
    run_op(4'd11, 16'h0123, 16'h0010, 16'h1230, 4'b0000, 1'b0, 17, 1'b1);
    run_op(4'd11, 16'hFFFF, 16'h0002, 16'hFFFE, 4'b0111, 1'b0, 17, 1'b0);
    run_op(4'd13, 16'h1234, 16'h5678, 16'hFFFE, 4'b0111, 1'b1, 1, 1'b0);
`else
    run_op(4'd13, 16'h1234, 16'h5678, 16'hF800, 4'b0100, 1'b1, 1, 1'b0);
    run_op(4'd11, 16'h0003, 16'h0004, 16'hF800, 4'b0100, 1'b1, 1, 1'b0);
`endif

    // Abort an op in flight with an asynchronous reset.
    @(negedge clk);
`ifdef ALU_MUL_EN
    bus.op = 4'd11; bus.a = 16'h0123; bus.b = 16'h0010; bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (7) @(posedge clk);
`else
    bus.op = 4'd0; bus.a = 16'h0001; bus.b = 16'h0001; bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
`endif
    #2;
    chk("busy_before_abort", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy",   32'(bus.busy),   32'h0);
    chk("abort_done",   32'(bus.done),   32'h0);
    chk("abort_result", 32'(bus.result), 32'h0);
    chk("abort_flags",  32'(bus.flags),  32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(4'd0, 16'h0002, 16'h0003, 16'h0005, 4'b0000, 1'b0, 1, 1'b0);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
